// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the pipe_reg register pipeline.
package pipe_pkg;

  // Longest pipeline for which the combinational ready chain is acceptable.
  localparam int MAX_DEPTH = 16;

  // Default value loaded into the data registers on reset.
  localparam int DEF_RST_VAL = 0;

  // Width of a counter that must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One pipeline stage: a data register plus its valid flag.
// Data only loads when the incoming valid is set, so a bubble moving in
// leaves the old data in place and saves a register toggle.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(DEF_RST_VAL)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  input  logic             v_d,
  output logic [WIDTH-1:0] q,
  output logic             v_q
);

  // Reset beats clear, clear beats load; clear leaves the data untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      q   <= RST_VAL;
      v_q <= 1'b0;
    end else if (clr) begin
      v_q <= 1'b0;
    end else if (load) begin
      v_q <= v_d;
      if (v_d) begin
        q <= d;
      end
    end
  end

endmodule

// File: rtl/pipe_reg.sv
// Bubble-collapsing register pipeline with valid/ready handshake,
// flush and registered occupancy count.
module pipe_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(DEF_RST_VAL),
  localparam int              CNT_W   = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [CNT_W-1:0] count
);

  if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_depth_chk
    $error("pipe_reg: DEPTH must be in 1..%0d", MAX_DEPTH);
  end

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] mv;
  logic             accept;
  logic             xfer;

  // A stage may move when it, or any stage downstream of it, is empty,
  // or when the output is draining. Built from a running OR to keep the
  // chain free of self-referencing vector bits.
  always_comb begin : p_mv
    logic run;
    run = out_ready;
    mv  = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      run   = run | ~v_q[k];
      mv[k] = run;
    end
  end

  assign in_ready  = mv[0] & ~flush;
  assign out_valid = v_q[DEPTH-1] & ~flush;
  assign out_data  = data_q[DEPTH-1];
  assign accept    = in_valid & in_ready;
  assign xfer      = out_valid & out_ready;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic [WIDTH-1:0] d_in;
    logic             v_in;

    if (k == 0) begin : g_head
      assign d_in = in_data;
      assign v_in = accept;
    end else begin : g_body
      assign d_in = data_q[k-1];
      assign v_in = v_q[k-1];
    end

    pipe_stage #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .clk  (clk),
      .rst  (rst),
      .load (mv[k] & ~flush),
      .clr  (flush),
      .d    (d_in),
      .v_d  (v_in),
      .q    (data_q[k]),
      .v_q  (v_q[k])
    );
  end

  // Occupancy tracks accepts against output transfers; flush empties it.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count <= '0;
    end else if (accept && !xfer) begin
      count <= count + CNT_W'(1);
    end else if (xfer && !accept) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_reg.sv
// Directed bench for pipe_reg, WIDTH=8, DEPTH=4, RST_VAL=8'h5A.
module tb_pipe_reg;

  localparam int         WIDTH = 8;
  localparam int         DEPTH = 4;
  localparam logic [7:0] RV    = 8'h5A;
  localparam int         CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_data;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_data;
  logic          flush;
  logic [CW-1:0] count;

  int n_chk = 0;
  int n_err = 0;

  pipe_reg #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .RST_VAL (RV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int req);
    n_chk++;
    if (obs !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, req, $time);
    end
  endtask

  // Drive point is 1 time unit after the rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int exp_d;
    int ecnt;

    // Reset held two cycles with traffic offered.
    rst = 1'b1; in_valid = 1'b1; in_data = 8'hAA; out_ready = 1'b0; flush = 1'b0;
    next_cycle();
    next_cycle();
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_out_data", out_data, RV);
    chk("rst_in_ready", in_ready, 1);
    next_cycle();
    rst = 1'b0; in_valid = 1'b0; in_data = 8'h00;

    // Streaming 0x01..0x10 with no backpressure.
    out_ready = 1'b1;
    for (int c = 0; c < 24; c++) begin
      next_cycle();
      in_valid = (c < 16);
      in_data  = 8'(c + 1);
      #1;
      if (c <= 4)       ecnt = c;
      else if (c <= 16) ecnt = 4;
      else if (c <= 20) ecnt = 20 - c;
      else              ecnt = 0;
      chk("stream_count", count, ecnt);
      chk("stream_out_valid", out_valid, (c >= 4 && c <= 19) ? 1 : 0);
      if (c >= 4 && c <= 19) chk("stream_out_data", out_data, c - 3);
      if (c < 16) chk("stream_in_ready", in_ready, 1);
    end

    // Backpressure: six offered, four accepted.
    out_ready = 1'b0;
    idx = 1;
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      in_valid = 1'b1;
      in_data  = 8'(idx);
      #1;
      chk("bp_in_ready", in_ready, (c < 4) ? 1 : 0);
      chk("bp_count", count, (c < 4) ? c : 4);
      if (c < 4) idx++;
    end
    next_cycle();
    in_valid = 1'b0;
    #1;
    chk("full_count", count, 4);
    chk("full_in_ready", in_ready, 0);
    chk("full_out_valid", out_valid, 1);
    chk("full_out_data", out_data, 1);

    // Release backpressure and drain, offering items 5 and 6.
    exp_d = 1;
    for (int c = 0; c < 12; c++) begin
      next_cycle();
      out_ready = 1'b1;
      in_valid  = (idx <= 6);
      in_data   = 8'(idx);
      #1;
      if (in_valid && in_ready) idx++;
      if (out_valid) begin
        chk("drain_data", out_data, exp_d);
        exp_d++;
      end
    end
    chk("drain_items", exp_d, 7);
    chk("drain_count", count, 0);

    // Bubbles: alternate valid with output stalled.
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      in_valid = (c % 2 == 0);
      in_data  = 8'(8'hA0 + c);
      #1;
    end
    next_cycle();
    in_valid = 1'b0;
    #1;
    chk("bub_count", count, 3);
    chk("bub_out_valid", out_valid, 1);
    chk("bub_out_data", out_data, 8'hA0);
    chk("bub_in_ready", in_ready, 1);

    // Flush with both handshakes requested.
    next_cycle();
    flush = 1'b1; in_valid = 1'b1; in_data = 8'hEE; out_ready = 1'b1;
    #1;
    chk("flush_in_ready", in_ready, 0);
    chk("flush_out_valid", out_valid, 0);
    next_cycle();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("post_flush_count", count, 0);
    chk("post_flush_out_valid", out_valid, 0);
    chk("post_flush_data_kept", out_data, 8'hA0);
    chk("post_flush_in_ready", in_ready, 1);

    // Traffic after flush: single item, DEPTH-cycle latency.
    next_cycle();
    in_valid = 1'b1; in_data = 8'h77;
    #1;
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      in_valid = 1'b0;
      #1;
      chk("aflush_out_valid", out_valid, (c == 4) ? 1 : 0);
      if (c == 4) chk("aflush_out_data", out_data, 8'h77);
    end
    next_cycle();
    #1;
    chk("aflush_count", count, 0);

    // Fill, then reset mid-operation.
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      in_valid = 1'b1;
      in_data  = 8'(8'h30 + c);
      #1;
    end
    next_cycle();
    in_valid = 1'b0;
    #1;
    chk("pre_rst_count", count, 4);
    next_cycle();
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", in_ready, 0);
    next_cycle();
    rst = 1'b0; in_valid = 1'b1; in_data = 8'h99; out_ready = 1'b1;
    #1;
    chk("mrst_count", count, 0);
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_out_data", out_data, RV);
    chk("mrst_in_ready", in_ready, 1);
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      in_valid = 1'b0;
      #1;
      chk("mrst_lat_valid", out_valid, (c == 4) ? 1 : 0);
      if (c == 4) chk("mrst_lat_data", out_data, 8'h99);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
